// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: debounces the roll button, animates a decelerating roll by resampling
// the free-running 1..FACES counter at growing intervals, then offers the final face on valid/ack.
module dice_roll_ctrl #(
    parameter int FACES           = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ROLL_STEPS      = 8,
    parameter int BASE_DELAY      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic [3:0] rng_value,
    input  logic       result_ack,
    output logic [3:0] roll_value,
    output logic       rolling,
    output logic [3:0] result,
    output logic       result_valid
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STEP_W  = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
    localparam int TIMER_W = (ROLL_STEPS * BASE_DELAY > 1) ? $clog2(ROLL_STEPS * BASE_DELAY) : 1;
    localparam logic [3:0] FACES_L = 4'(FACES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        DONE = 2'd2
    } state_t;

    logic              sync1_q;
    logic              sync2_q;
    logic              dbLevel_q;
    logic              dbPrev_q;
    logic [DB_W-1:0]   dbCount_q;
    logic              press;

    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic [TIMER_W-1:0] timer_q;
    logic [3:0]        rollValue_q;
    logic [3:0]        result_q;
    logic              resultValid_q;
    logic              rolling_q;

    logic [3:0]        sampleFace;
    logic [TIMER_W-1:0] stepLimit;
    logic              stepDue;
    logic              lastStep;

    // The debounced level only moves after a full run of samples that disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dbLevel_q <= 1'b0;
            dbPrev_q  <= 1'b0;
            dbCount_q <= '0;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            dbPrev_q <= dbLevel_q;
            if (sync2_q != dbLevel_q) begin
                if (dbCount_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    dbLevel_q <= sync2_q;
                    dbCount_q <= '0;
                end else begin
                    dbCount_q <= dbCount_q + 1'b1;
                end
            end else begin
                dbCount_q <= '0;
            end
        end
    end

    assign press      = dbLevel_q & ~dbPrev_q;
    assign sampleFace = ((rng_value == 4'd0) || (rng_value > FACES_L)) ? 4'd1 : rng_value;
    assign stepLimit  = TIMER_W'((int'(step_q) + 1) * BASE_DELAY - 1);
    assign stepDue    = (timer_q == stepLimit);
    assign lastStep   = (step_q == STEP_W'(ROLL_STEPS - 1));

    // Wait before step k is k*BASE_DELAY cycles, so the roll visibly slows down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            step_q        <= '0;
            timer_q       <= '0;
            rollValue_q   <= 4'd0;
            result_q      <= 4'd0;
            resultValid_q <= 1'b0;
            rolling_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q     <= ROLL;
                        step_q      <= '0;
                        timer_q     <= '0;
                        rolling_q   <= 1'b1;
                        rollValue_q <= sampleFace;
                    end
                end
                ROLL: begin
                    if (stepDue) begin
                        rollValue_q <= sampleFace;
                        timer_q     <= '0;
                        if (lastStep) begin
                            step_q        <= '0;
                            result_q      <= sampleFace;
                            resultValid_q <= 1'b1;
                            rolling_q     <= 1'b0;
                            state_q       <= DONE;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        resultValid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign roll_value   = rollValue_q;
    assign rolling      = rolling_q;
    assign result       = result_q;
    assign result_valid = resultValid_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl: reset, debounce rejection, full rolls with hand-picked
// samples at each resample offset, out-of-range replacement, DONE handshake and mid-roll reset.
module tb_dice_roll_ctrl;

    logic       clk;
    logic       reset;
    logic       button;
    logic [3:0] rng_value;
    logic       result_ack;
    logic [3:0] roll_value;
    logic       rolling;
    logic [3:0] result;
    logic       result_valid;

    int compared;
    int mismatched;

    logic [3:0] rngSeq [9];
    logic [3:0] expSeq [9];
    localparam int OFFS [9] = '{0, 4, 12, 24, 40, 60, 84, 112, 144};

    dice_roll_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .button       (button),
        .rng_value    (rng_value),
        .result_ack   (result_ack),
        .roll_value   (roll_value),
        .rolling      (rolling),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presses the button, then steps through each resample offset checking hold and update.
    task automatic applyStimulus();
        int waitCycles;
        rng_value  = rngSeq[0];
        button     = 1'b1;
        waitCycles = 0;
        while (rolling !== 1'b1 && waitCycles < 60) begin
            tick(1);
            waitCycles++;
        end
        checkOutput("rollStart", {3'b0, rolling}, 4'h1);
        checkOutput("entrySample", roll_value, expSeq[0]);
        for (int k = 1; k < 9; k++) begin
            rng_value = rngSeq[k];
            tick(OFFS[k] - OFFS[k-1] - 1);
            checkOutput($sformatf("hold%0d", k), roll_value, expSeq[k-1]);
            checkOutput($sformatf("rollingHigh%0d", k), {3'b0, rolling}, 4'h1);
            tick(1);
            checkOutput($sformatf("sample%0d", k), roll_value, expSeq[k]);
        end
        checkOutput("rollingLow", {3'b0, rolling}, 4'h0);
        checkOutput("validSet", {3'b0, result_valid}, 4'h1);
        checkOutput("resultFace", result, expSeq[8]);
    endtask

    task automatic ackAndRelease(input logic [3:0] face);
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        checkOutput("ackClears", {3'b0, result_valid}, 4'h0);
        checkOutput("ackKeepsResult", result, face);
        button = 1'b0;
        tick(25);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        button     = 1'b0;
        rng_value  = 4'd3;
        result_ack = 1'b0;
        tick(2);
        checkOutput("rstRoll", roll_value, 4'h0);
        checkOutput("rstValid", {3'b0, result_valid}, 4'h0);
        checkOutput("rstRolling", {3'b0, rolling}, 4'h0);
        checkOutput("rstResult", result, 4'h0);
        reset = 1'b0;
        tick(2);

        // Short glitch of 10 cycles must not count as a press
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(30);
        checkOutput("glitchRolling", {3'b0, rolling}, 4'h0);
        checkOutput("glitchRoll", roll_value, 4'h0);
        checkOutput("glitchValid", {3'b0, result_valid}, 4'h0);

        // Full roll with in-range samples
        rngSeq = '{4'd3, 4'd5, 4'd2, 4'd6, 4'd4, 4'd1, 4'd3, 4'd5, 4'd2};
        expSeq = '{4'd3, 4'd5, 4'd2, 4'd6, 4'd4, 4'd1, 4'd3, 4'd5, 4'd2};
        applyStimulus();

        // Release and re-press in DONE without ack: dropped
        button = 1'b0;
        tick(25);
        button = 1'b1;
        tick(25);
        checkOutput("donePressValid", {3'b0, result_valid}, 4'h1);
        checkOutput("donePressRolling", {3'b0, rolling}, 4'h0);
        checkOutput("donePressRoll", roll_value, 4'h2);
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        checkOutput("ackClears1", {3'b0, result_valid}, 4'h0);
        checkOutput("ackKeeps1", result, 4'h2);
        tick(5);
        checkOutput("noQueuedPress", {3'b0, rolling}, 4'h0);
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        checkOutput("idleAckValid", {3'b0, result_valid}, 4'h0);
        checkOutput("idleAckResult", result, 4'h2);
        checkOutput("idleShowsLast", roll_value, 4'h2);
        button = 1'b0;
        tick(25);

        // Out-of-range samples are replaced by 1
        rngSeq = '{4'd0, 4'd7, 4'd4, 4'd0, 4'd9, 4'd2, 4'd15, 4'd5, 4'd7};
        expSeq = '{4'd1, 4'd1, 4'd4, 4'd1, 4'd1, 4'd2, 4'd1,  4'd5, 4'd1};
        applyStimulus();
        ackAndRelease(4'd1);

        // Reset at ROLL offset 50 aborts the roll asynchronously
        rng_value = 4'd2;
        button    = 1'b1;
        begin
            int waitCycles;
            waitCycles = 0;
            while (rolling !== 1'b1 && waitCycles < 60) begin
                tick(1);
                waitCycles++;
            end
        end
        checkOutput("abortStart", {3'b0, rolling}, 4'h1);
        tick(50);
        checkOutput("abortMidRolling", {3'b0, rolling}, 4'h1);
        reset  = 1'b1;
        button = 1'b0;
        #1;
        checkOutput("asyncRoll", roll_value, 4'h0);
        checkOutput("asyncRolling", {3'b0, rolling}, 4'h0);
        checkOutput("asyncValid", {3'b0, result_valid}, 4'h0);
        checkOutput("asyncResult", result, 4'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        checkOutput("postRstRolling", {3'b0, rolling}, 4'h0);
        checkOutput("postRstValid", {3'b0, result_valid}, 4'h0);

        rngSeq = '{4'd6, 4'd1, 4'd5, 4'd3, 4'd6, 4'd2, 4'd4, 4'd1, 4'd6};
        expSeq = '{4'd6, 4'd1, 4'd5, 4'd3, 4'd6, 4'd2, 4'd4, 4'd1, 4'd6};
        applyStimulus();
        ackAndRelease(4'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
